// File: rtl/apb_master_mux_if.sv
// apb_master_mux_if: request/response port and APB segment of apb_master_mux.
//   req_*   : valid/ready request from the front end (req_ready driven by master)
//   rsp_*   : one-cycle response pulse with read data and error flags
//   P*      : APB4 bus with per-slave PSEL/PREADY/PRDATA/PSLVERR
// Modports: master (the requester), slave (the front end plus APB slaves).
interface apb_master_mux_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_SLAVES = 4
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [ADDR_W-1:0]            req_addr;
    logic [DATA_W-1:0]            req_wdata;
    logic [STRB_W-1:0]            req_strb;
    logic [2:0]                   req_prot;

    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;
    logic                         rsp_timeout;

    logic [ADDR_W-1:0]            PADDR;
    logic [2:0]                   PPROT;
    logic [NUM_SLAVES-1:0]        PSEL;
    logic                         PENABLE;
    logic                         PWRITE;
    logic [DATA_W-1:0]            PWDATA;
    logic [STRB_W-1:0]            PSTRB;
    logic [NUM_SLAVES-1:0]        PREADY;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]        PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_master_mux.sv
// apb_master_mux: APB4 requester with integrated slave decoder and access timeout.
// Accepts one register request at a time, runs SETUP/ACCESS to the slave selected
// by req_addr[SLV_SHIFT +: SEL_W], and returns a one-cycle response pulse.
// Ports:
//   PCLK      : clock, rising edge
//   PRESET    : synchronous active-high reset
//   bus       : apb_master_mux_if.master (request, response and APB signals)
//   Out_State : current state (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
module apb_master_mux #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SLV_SHIFT  = 12,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    apb_master_mux_if.master        bus,
    output logic [1:0]              Out_State
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          TO_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;

    logic                  req_ready_c;
    logic [SEL_W-1:0]      req_idx;
    logic                  req_in_range;
    logic [NUM_SLAVES-1:0] req_onehot;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_W-1:0]     sel_rdata;

    assign req_ready_c = (state_q == IDLE) && !PRESET;

    // Slave index decode; non-power-of-two slave counts leave some indices unmapped
    assign req_idx      = bus.req_addr[SLV_SHIFT +: SEL_W];
    assign req_in_range = (32'(req_idx) < 32'(NUM_SLAVES));

    always_comb begin
        req_onehot = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            req_onehot[i] = (req_idx == SEL_W'(i));
        end
    end

    // Only the selected slave's response is looked at
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = bus.PREADY[i];
                sel_err   = bus.PSLVERR[i];
                sel_rdata = bus.PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // State and output registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pprot_q       <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
            sel_q         <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pprot_q       <= pprot_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pprot_d       = pprot_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_c) begin
                    paddr_d  = bus.req_addr;
                    pprot_d  = bus.req_prot;
                    pwrite_d = bus.req_write;
                    pwdata_d = bus.req_wdata;
                    pstrb_d  = bus.req_write ? bus.req_strb : '0;
                    sel_d    = req_idx;
                    cnt_d    = '0;
                    if (req_in_range) begin
                        psel_d  = req_onehot;
                        state_d = SETUP;
                    end else begin
                        // Decode error: no APB transfer, answer immediately
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                        state_d       = RESP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    // Ready beats a simultaneous timeout
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = sel_err;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (pwrite_q || sel_err) ? '0 : sel_rdata;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (TO_EN && (cnt_q == CNT_LAST)) begin
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_rdata_d   = '0;
                        psel_d        = '0;
                        penable_d     = 1'b0;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PPROT       = pprot_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PSTRB       = pstrb_q;
    assign Out_State       = state_q;
endmodule

// File: tb/tb_apb_master_mux.sv
// tb_apb_master_mux: directed checks of apb_master_mux (4-slave instance) plus a
// 3-slave instance for the address-decode error path.
module tb_apb_master_mux;
    logic       PCLK = 1'b0;
    logic       PRESET;
    logic [1:0] state4;
    logic [1:0] state3;
    int         n_checks = 0;
    int         n_fails  = 0;

    apb_master_mux_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4)) bus4 ();
    apb_master_mux_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) bus3 ();

    apb_master_mux #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .SLV_SHIFT(12), .TIMEOUT(16)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .bus       (bus4),
        .Out_State (state4)
    );

    apb_master_mux #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3), .SLV_SHIFT(12), .TIMEOUT(16)) dut3 (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .bus       (bus3),
        .Out_State (state3)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Present one request on bus4 and return one cycle after the accepting edge (T1)
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot);
        int waited = 0;
        while (!bus4.req_ready && waited < 50) begin
            step();
            waited++;
        end
        if (waited >= 50) check("issue_ready_timeout", 64'd0, 64'd1);
        bus4.req_write = wr;
        bus4.req_addr  = addr;
        bus4.req_wdata = wdata;
        bus4.req_strb  = strb;
        bus4.req_prot  = prot;
        bus4.req_valid = 1'b1;
        step();
        bus4.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET         = 1'b1;
        bus4.req_valid = 1'b0;
        bus4.req_write = 1'b0;
        bus4.req_addr  = '0;
        bus4.req_wdata = '0;
        bus4.req_strb  = '0;
        bus4.req_prot  = '0;
        bus4.PREADY    = '0;
        bus4.PRDATA    = '0;
        bus4.PSLVERR   = '0;
        bus3.req_valid = 1'b0;
        bus3.req_write = 1'b0;
        bus3.req_addr  = '0;
        bus3.req_wdata = '0;
        bus3.req_strb  = '0;
        bus3.req_prot  = '0;
        bus3.PREADY    = 3'b111;
        bus3.PRDATA    = '0;
        bus3.PSLVERR   = '0;

        // Reset state
        step();
        step();
        check("rst_state",    64'(state4),         64'd0);
        check("rst_psel",     64'(bus4.PSEL),      64'd0);
        check("rst_penable",  64'(bus4.PENABLE),   64'd0);
        check("rst_paddr",    64'(bus4.PADDR),     64'd0);
        check("rst_rsp",      64'(bus4.rsp_valid), 64'd0);
        check("rst_ready_lo", 64'(bus4.req_ready), 64'd0);
        PRESET = 1'b0;
        #1;
        check("rst_ready_hi", 64'(bus4.req_ready), 64'd1);

        // Zero-wait write to slave 1
        bus4.PREADY = 4'b0010;
        issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b010);
        check("wr_t1_state",   64'(state4),        64'd1);
        check("wr_t1_psel",    64'(bus4.PSEL),     64'h2);
        check("wr_t1_penable", 64'(bus4.PENABLE),  64'd0);
        check("wr_t1_paddr",   64'(bus4.PADDR),    64'h1004);
        check("wr_t1_pwrite",  64'(bus4.PWRITE),   64'd1);
        check("wr_t1_pwdata",  64'(bus4.PWDATA),   64'hDEAD_BEEF);
        check("wr_t1_pstrb",   64'(bus4.PSTRB),    64'hF);
        check("wr_t1_pprot",   64'(bus4.PPROT),    64'h2);
        check("wr_t1_ready",   64'(bus4.req_ready),64'd0);
        step();
        check("wr_t2_state",   64'(state4),        64'd2);
        check("wr_t2_psel",    64'(bus4.PSEL),     64'h2);
        check("wr_t2_penable", 64'(bus4.PENABLE),  64'd1);
        check("wr_t2_rsp",     64'(bus4.rsp_valid),64'd0);
        step();
        check("wr_t3_rsp",     64'(bus4.rsp_valid),64'd1);
        check("wr_t3_err",     64'(bus4.rsp_err),  64'd0);
        check("wr_t3_rdata",   64'(bus4.rsp_rdata),64'd0);
        check("wr_t3_psel",    64'(bus4.PSEL),     64'd0);
        check("wr_t3_penable", 64'(bus4.PENABLE),  64'd0);
        step();
        check("wr_t4_rsp",     64'(bus4.rsp_valid),64'd0);
        check("wr_t4_ready",   64'(bus4.req_ready),64'd1);

        // Read from slave 3 with three wait states; other slaves ready but ignored
        bus4.PREADY = 4'b0111;
        bus4.PRDATA = {32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        issue(1'b0, 32'h0000_3010, 32'h5555_0000, 4'hF, 3'b000);
        check("rd_t1_psel",  64'(bus4.PSEL),  64'h8);
        check("rd_t1_pstrb", 64'(bus4.PSTRB), 64'h0);
        for (int c = 2; c <= 5; c++) begin
            step();
            check($sformatf("rd_t%0d_state", c), 64'(state4),     64'd2);
            check($sformatf("rd_t%0d_paddr", c), 64'(bus4.PADDR), 64'h3010);
            if (c == 5) bus4.PREADY = 4'b1000;
        end
        step();
        check("rd_t6_rsp",     64'(bus4.rsp_valid),  64'd1);
        check("rd_t6_rdata",   64'(bus4.rsp_rdata),  64'h1234_5678);
        check("rd_t6_err",     64'(bus4.rsp_err),    64'd0);
        check("rd_t6_timeout", 64'(bus4.rsp_timeout),64'd0);
        step();
        check("rd_hold_rdata", 64'(bus4.rsp_rdata),  64'h1234_5678);

        // Read from slave 2 answered with PSLVERR
        bus4.PREADY  = 4'b0100;
        bus4.PSLVERR = 4'b0100;
        bus4.PRDATA  = {32'h0, 32'hAAAA_5555, 32'h0, 32'h0};
        issue(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b001);
        check("se_t1_psel", 64'(bus4.PSEL), 64'h4);
        step();
        step();
        check("se_rsp",     64'(bus4.rsp_valid),  64'd1);
        check("se_err",     64'(bus4.rsp_err),    64'd1);
        check("se_timeout", 64'(bus4.rsp_timeout),64'd0);
        check("se_rdata",   64'(bus4.rsp_rdata),  64'd0);
        bus4.PSLVERR = '0;
        bus4.PREADY  = '0;
        step();

        // Slave 0 never ready: abort after 16 ACCESS cycles
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b000);
        check("to_t1_state", 64'(state4), 64'd1);
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 1 || c == 16) begin
                check($sformatf("to_acc%0d_state", c), 64'(state4),       64'd2);
                check($sformatf("to_acc%0d_pen", c),   64'(bus4.PENABLE), 64'd1);
            end
        end
        step();
        check("to_rsp",     64'(bus4.rsp_valid),  64'd1);
        check("to_err",     64'(bus4.rsp_err),    64'd1);
        check("to_timeout", 64'(bus4.rsp_timeout),64'd1);
        check("to_psel",    64'(bus4.PSEL),       64'd0);
        check("to_penable", 64'(bus4.PENABLE),    64'd0);
        step();

        // Next request after a timeout completes normally
        bus4.PREADY = 4'b0001;
        issue(1'b1, 32'h0000_0008, 32'h0000_00A5, 4'h1, 3'b000);
        check("post_to_pstrb", 64'(bus4.PSTRB), 64'h1);
        step();
        step();
        check("post_to_rsp",     64'(bus4.rsp_valid),  64'd1);
        check("post_to_err",     64'(bus4.rsp_err),    64'd0);
        check("post_to_timeout", 64'(bus4.rsp_timeout),64'd0);
        step();

        // PREADY on the 16th ACCESS cycle wins over the timeout
        bus4.PREADY = '0;
        bus4.PRDATA = {32'h0, 32'h0, 32'h0, 32'hCAFE_F00D};
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b000);
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 16) bus4.PREADY = 4'b0001;
        end
        step();
        check("late_rsp",     64'(bus4.rsp_valid),  64'd1);
        check("late_err",     64'(bus4.rsp_err),    64'd0);
        check("late_timeout", 64'(bus4.rsp_timeout),64'd0);
        check("late_rdata",   64'(bus4.rsp_rdata),  64'hCAFE_F00D);
        step();

        // Reset during ACCESS
        bus4.PREADY = '0;
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000);
        step();
        check("mr_pre_state", 64'(state4), 64'd2);
        PRESET = 1'b1;
        step();
        check("mr_psel",     64'(bus4.PSEL),      64'd0);
        check("mr_penable",  64'(bus4.PENABLE),   64'd0);
        check("mr_state",    64'(state4),         64'd0);
        check("mr_rsp",      64'(bus4.rsp_valid), 64'd0);
        check("mr_rdata",    64'(bus4.rsp_rdata), 64'd0);
        check("mr_ready_lo", 64'(bus4.req_ready), 64'd0);
        PRESET = 1'b0;
        #1;
        check("mr_ready_hi", 64'(bus4.req_ready), 64'd1);
        step();
        check("mr_rsp_after", 64'(bus4.rsp_valid), 64'd0);

        // Decode error on the 3-slave instance: index 3 is unmapped
        bus3.req_write = 1'b0;
        bus3.req_addr  = 32'h0000_3000;
        bus3.req_valid = 1'b1;
        check("de_ready", 64'(bus3.req_ready), 64'd1);
        step();
        bus3.req_valid = 1'b0;
        check("de_t1_state", 64'(state3),          64'd3);
        check("de_t1_psel",  64'(bus3.PSEL),       64'd0);
        check("de_t1_rsp",   64'(bus3.rsp_valid),  64'd1);
        check("de_t1_err",   64'(bus3.rsp_err),    64'd1);
        check("de_t1_to",    64'(bus3.rsp_timeout),64'd0);
        step();
        check("de_t2_state", 64'(state3),          64'd0);
        check("de_t2_rsp",   64'(bus3.rsp_valid),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
